uart_rx_frame_checker: RTL and testbench

UART_RX_FRAME_CHECKER -- requirements
Module: uart_rx_frame_checker

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_rx_frame_checker.sv | 121 ++++++++++++
 tb/tb_uart_rx_frame_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive frame checker: parity modes, flag bit
// positions and the parity-error helper.
package uart_pkg;

  typedef enum logic [1:0] {
    NOPARITY00 = 2'b00,
    ODD        = 2'b01,
    EVEN       = 2'b10,
    NOPARITY11 = 2'b11
  } parity_t;

  // Bit positions shared by out_err[3:0] and err_status[4:0]
  localparam int ERR_PARITY  = 0;
  localparam int ERR_START   = 1;
  localparam int ERR_STOP    = 2;
  localparam int ERR_BREAK   = 3;
  localparam int ERR_OVERRUN = 4;

  function automatic logic parity_enabled(input parity_t pt);
    return (pt == ODD) || (pt == EVEN);
  endfunction

  // xor_all is the reduction XOR of the data bits together with the parity bit
  function automatic logic parity_error(input parity_t pt, input logic xor_all);
    case (pt)
      ODD:     return ~xor_all;
      EVEN:    return xor_all;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for checked frames; the head is presented
// combinationally and forced to zero while the FIFO is empty.
module uart_rx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Checks each received UART frame for parity, start, stop and break conditions.
// It buffers the data and flags, and keeps sticky status plus saturating error counters.
module uart_rx_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_valid,
  input  logic [DATA_W-1:0] frame_data,
  input  logic              start_bit,
  input  logic              parity_bit,
  input  logic [1:0]        stop_bits,
  input  logic [1:0]        parity_type,
  input  logic              two_stop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_err,
  output logic [4:0]        err_status,
  input  logic [4:0]        status_clr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_parity,
  output logic [CNT_W-1:0]  cnt_start,
  output logic [CNT_W-1:0]  cnt_stop,
  output logic [CNT_W-1:0]  cnt_overrun
);

  parity_t    ptype;
  logic [3:0] flags;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       push;
  logic       overrun;

  assign ptype = parity_t'(parity_type);

  always_comb begin
    flags             = '0;
    flags[ERR_PARITY] = parity_error(ptype, ^{frame_data, parity_bit});
    flags[ERR_START]  = start_bit;
    flags[ERR_STOP]   = ~stop_bits[0] | (two_stop & ~stop_bits[1]);
    flags[ERR_BREAK]  = (frame_data == '0) & ~start_bit & ~stop_bits[0] &
                        (~parity_bit | ~parity_enabled(ptype));
  end

  // A full buffer still takes a frame when the head leaves in the same cycle
  assign pop     = out_valid & out_ready;
  assign push    = frame_valid & (~fifo_full | pop);
  assign overrun = frame_valid & fifo_full & ~pop;

  uart_rx_fifo #(
    .WIDTH(DATA_W + 4),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    ({frame_data, flags}),
    .dout   ({out_data, out_err}),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = ~fifo_empty;

  logic [4:0] status_q, status_d;
  logic [4:0] status_set;

  // Sets are applied after clears, so a same-cycle set wins
  always_comb begin
    status_set              = '0;
    status_set[3:0]         = push ? flags : 4'b0000;
    status_set[ERR_OVERRUN] = overrun;
    status_d                = (status_q & ~status_clr) | status_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_q <= '0;
    else          status_q <= status_d;
  end

  assign err_status = status_q;

  // Counter order: 0 parity, 1 start, 2 stop, 3 overrun
  logic [3:0]            cnt_inc;
  logic [3:0][CNT_W-1:0] cnt_vec;

  assign cnt_inc = {overrun,
                    push & flags[ERR_STOP],
                    push & flags[ERR_START],
                    push & flags[ERR_PARITY]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)                         cnt_d = CNT_W'(cnt_inc[gi]);
      else if (cnt_inc[gi] && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign cnt_vec[gi] = cnt_q;
  end

  assign cnt_parity  = cnt_vec[0];
  assign cnt_start   = cnt_vec[1];
  assign cnt_stop    = cnt_vec[2];
  assign cnt_overrun = cnt_vec[3];

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker: frames are queued as expected
// {data, flags} at issue time and a negedge monitor checks every popped head.
module tb_uart_rx_frame_checker;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              frame_valid;
  logic [DATA_W-1:0] frame_data;
  logic              start_bit;
  logic              parity_bit;
  logic [1:0]        stop_bits;
  logic [1:0]        parity_type;
  logic              two_stop;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_err;
  logic [4:0]        err_status;
  logic [4:0]        status_clr;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_parity;
  logic [CNT_W-1:0]  cnt_start;
  logic [CNT_W-1:0]  cnt_stop;
  logic [CNT_W-1:0]  cnt_overrun;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q [$];

  uart_rx_frame_checker #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .start_bit  (start_bit),
    .parity_bit (parity_bit),
    .stop_bits  (stop_bits),
    .parity_type(parity_type),
    .two_stop   (two_stop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .err_status (err_status),
    .status_clr (status_clr),
    .cnt_clr    (cnt_clr),
    .cnt_parity (cnt_parity),
    .cnt_start  (cnt_start),
    .cnt_stop   (cnt_stop),
    .cnt_overrun(cnt_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got data=%0h err=%b expected no output", out_data, out_err);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({out_data, out_err} !== e) begin
          bad++;
          $display("FAIL pop: got data=%0h err=%b expected data=%0h err=%b",
                   out_data, out_err, e[11:4], e[3:0]);
        end else begin
          $display("ok   pop: data=%0h err=%b", out_data, out_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sb, input logic pb,
                      input logic [1:0] sp, input logic [1:0] pt, input logic ts,
                      input logic acc, input logic [3:0] exp_err);
    if (acc) exp_q.push_back({d, exp_err});
    frame_data  = d;
    start_bit   = sb;
    parity_bit  = pb;
    stop_bits   = sp;
    parity_type = pt;
    two_stop    = ts;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    frame_data  = 8'hxx;
    start_bit   = 1'bx;
    parity_bit  = 1'bx;
    stop_bits   = 2'bxx;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    start_bit   = 1'b0;
    parity_bit  = 1'b0;
    stop_bits   = 2'b11;
    parity_type = 2'b00;
    two_stop    = 1'b1;
    out_ready   = 1'b1;
    status_clr  = '0;
    cnt_clr     = 1'b0;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_status", err_status, 0);
    check("rst_counters", {cnt_parity, cnt_start, cnt_stop, cnt_overrun}, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Parity: A5 has four ones
    send(8'hA5, 0, 0, 2'b11, 2'b10, 1, 1, 4'b0000);
    check("even_ok_valid", out_valid, 1);
    check("even_ok_err", out_err, 4'b0000);
    send(8'hA5, 0, 1, 2'b11, 2'b10, 1, 1, 4'b0001);
    check("even_bad_err", out_err, 4'b0001);
    check("cnt_parity_1", cnt_parity, 1);
    send(8'h01, 0, 0, 2'b11, 2'b01, 1, 1, 4'b0000);
    send(8'h03, 0, 0, 2'b11, 2'b01, 1, 1, 4'b0001);
    send(8'h03, 0, 0, 2'b11, 2'b11, 1, 1, 4'b0000);
    check("cnt_parity_2", cnt_parity, 2);

    // Stop bits
    send(8'h5A, 0, 0, 2'b01, 2'b00, 0, 1, 4'b0000);
    send(8'h5A, 0, 0, 2'b01, 2'b00, 1, 1, 4'b0100);
    send(8'h5A, 0, 0, 2'b10, 2'b00, 0, 1, 4'b0100);
    check("cnt_stop_2", cnt_stop, 2);

    // Break after a full status clear
    status_clr = 5'h1F;
    tick();
    status_clr = 5'h00;
    check("status_cleared", err_status, 0);
    send(8'h00, 0, 0, 2'b00, 2'b10, 1, 1, 4'b1100);
    check("break_status", err_status, 5'b01100);
    check("cnt_stop_sat", cnt_stop, 3);

    // Clear of bit 0 while a parity error sets it
    status_clr = 5'b00001;
    send(8'hA5, 0, 1, 2'b11, 2'b10, 1, 1, 4'b0001);
    status_clr = 5'b00000;
    check("clr_vs_set", err_status, 5'b01101);
    check("cnt_parity_3", cnt_parity, 3);

    // Start errors saturate a 2-bit counter, then clear-with-increment
    for (int i = 0; i < 5; i++) send(8'h55, 1, 0, 2'b11, 2'b00, 1, 1, 4'b0010);
    check("cnt_start_sat", cnt_start, 3);
    cnt_clr = 1'b1;
    send(8'h55, 1, 0, 2'b11, 2'b00, 1, 1, 4'b0010);
    cnt_clr = 1'b0;
    check("cnt_start_clr_inc", cnt_start, 1);
    check("cnt_parity_clr", cnt_parity, 0);
    check("cnt_stop_clr", cnt_stop, 0);
    drain();

    // Overrun with a stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 0, 0, 2'b11, 2'b00, 1, 1, 4'b0000);
    send(8'h14, 0, 0, 2'b11, 2'b00, 1, 0, 4'b0000);
    check("cnt_overrun_1", cnt_overrun, 1);
    check("overrun_sticky", err_status[4], 1);
    check("head_hold_a", out_data, 8'h10);
    tick();
    check("head_hold_b", out_data, 8'h10);
    out_ready = 1'b1;
    send(8'h15, 0, 0, 2'b11, 2'b00, 1, 1, 4'b0000);
    check("full_pop_no_overrun", cnt_overrun, 1);
    drain();

    // Asynchronous reset with frames buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h21 + 8'(i), 1, 0, 2'b11, 2'b00, 1, 1, 4'b0010);
    check("pre_reset_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_valid", out_valid, 0);
    check("async_rst_counters", {cnt_parity, cnt_start, cnt_stop, cnt_overrun}, 0);
    check("async_rst_status", err_status, 0);
    #3;
    reset_n = 1'b1;
    send(8'h3C, 0, 0, 2'b11, 2'b00, 1, 1, 4'b0000);
    check("first_after_rst_valid", out_valid, 1);
    check("first_after_rst_data", out_data, 8'h3C);
    out_ready = 1'b1;
    drain();
    tick();
    check("final_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
